mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 120 ++++++++++++
 tb/tb_mul_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb.sv
// Two-requester round-robin arbiter in front of a shift-add multiplier.
// One accepted request is multiplied over WIDTH cycles; the result is held
// with res_valid until the consumer takes it, then the arbiter reopens.
module mul_arb #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [WIDTH-1:0]     op_a0,
    input  logic [WIDTH-1:0]     op_b0,
    input  logic [WIDTH-1:0]     op_a1,
    input  logic [WIDTH-1:0]     op_b1,
    output logic [1:0]           req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   mul_out,
    output logic                 res_id,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               id_q;
    logic               prio;      // requester favoured when both are valid
    logic               grant_id;
    logic               accept;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] addend;

    // Grant selection: only offered in IDLE and never while reset is high
    always_comb begin
        req_ready = 2'b00;
        grant_id  = 1'b0;
        if (state == IDLE && !reset) begin
            case (req_valid)
                2'b01: begin
                    req_ready = 2'b01;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    req_ready = 2'b10;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_id  = prio;
                    req_ready = prio ? 2'b10 : 2'b01;
                end
                default: begin
                    req_ready = 2'b00;
                    grant_id  = 1'b0;
                end
            endcase
        end
    end

    assign accept = |(req_valid & req_ready);

    // Partial product for the multiplier bit selected by the iteration counter
    always_comb begin
        a_ext  = {{WIDTH{1'b0}}, a_q};
        addend = b_q[count] ? (a_ext << count) : '0;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            count <= '0;
            id_q  <= 1'b0;
            prio  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= grant_id ? op_a1 : op_a0;
                        b_q   <= grant_id ? op_b1 : op_b0;
                        id_q  <= grant_id;
                        acc   <= '0;
                        count <= '0;
                        prio  <= ~grant_id;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc + addend;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign mul_out   = acc;
    assign res_id    = id_q;

endmodule

// File: tb/tb_mul_arb.sv
// Scoreboard bench for mul_arb: stimulus pushes expected {id, product},
// a negedge monitor pops and compares on every result handshake.
module tb_mul_arb;

    localparam int W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [W-1:0]     op_a0, op_b0, op_a1, op_b1;
    logic [1:0]       req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [2*W-1:0]   mul_out;
    logic             res_id;
    logic             busy;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mprio;

    mul_arb #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .op_a0     (op_a0),
        .op_b0     (op_b0),
        .op_a1     (op_a1),
        .op_b1     (op_b1),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .mul_out   (mul_out),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every result handshake against the scoreboard head
    always @(negedge clk) begin
        if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d id %0d, expected none", mul_out, res_id);
            end else begin
                mon_e = sb.pop_front();
                chk("result_value", 32'(mul_out), 32'(mon_e.prod));
                chk("result_id", 32'(res_id), 32'(mon_e.id));
            end
        end
    end

    // Drive a request, wait (bounded) for the grant, check it against the
    // reference arbiter and push the expected result. Returns after accept edge.
    task automatic request(input logic [1:0] v, input logic [W-1:0] a0, b0, a1, b1);
        logic           g;
        logic [2*W-1:0] ea, eb;
        bit             got;
        req_valid = v;
        op_a0 = a0; op_b0 = b0; op_a1 = a1; op_b1 = b1;
        g = (v == 2'b10) ? 1'b1 : (v == 2'b11) ? mprio : 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got req_ready %b, expected a grant", req_ready);
        end else begin
            chk("req_ready_grant", 32'(req_ready), g ? 32'd2 : 32'd1);
        end
        ea = g ? {{W{1'b0}}, a1} : {{W{1'b0}}, a0};
        eb = g ? {{W{1'b0}}, b1} : {{W{1'b0}}, b0};
        sb.push_back('{id: g, prod: ea * eb});
        mprio = ~g;
        @(posedge clk);
        #1;
    endtask

    // From the accept edge: res_valid must rise exactly W cycles later,
    // with no grant offered and busy high throughout.
    task automatic latency();
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            chk("res_valid_latency", 32'(res_valid), (k == W) ? 32'd1 : 32'd0);
            chk("req_ready_quiet", 32'(req_ready), 32'd0);
            chk("busy_high", 32'(busy), 32'd1);
        end
    endtask

    task automatic handshake();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
        op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
        mprio = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("req_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        chk("rst_mul_out", 32'(mul_out), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // 31*31 = 961, busy falls after the handshake
        request(2'b01, 5'd31, 5'd31, 5'd0, 5'd0);
        req_valid = 2'b00;
        latency();
        handshake();
        @(negedge clk);
        chk("busy_after_hs", 32'(busy), 32'd0);
        chk("res_valid_after_hs", 32'(res_valid), 32'd0);

        // Both valid: req0 first (3*7=21), then req1 (12*10=120)
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; mprio = 1'b0;
        request(2'b11, 5'd3, 5'd7, 5'd12, 5'd10);
        req_valid = 2'b10;
        latency();
        handshake();
        request(2'b10, 5'd3, 5'd7, 5'd12, 5'd10);
        req_valid = 2'b00;
        latency();
        handshake();

        // Continuous requests from both: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            request(2'b11, 5'd5, 5'd6, 5'd7, 5'd9);
            latency();
            handshake();
        end
        req_valid = 2'b00;

        // Backpressure: 9*5 = 45 held stable while res_ready is low
        res_ready = 1'b0;
        request(2'b01, 5'd9, 5'd5, 5'd0, 5'd0);
        req_valid = 2'b00;
        latency();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_mul_out", 32'(mul_out), 32'd45);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        handshake();
        @(negedge clk);
        chk("bp_single_hs", 32'(res_valid), 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        // Zero and identity operands
        request(2'b01, 5'd0, 5'd17, 5'd0, 5'd0);
        req_valid = 2'b00; latency(); handshake();
        request(2'b01, 5'd17, 5'd1, 5'd0, 5'd0);
        req_valid = 2'b00; latency(); handshake();
        request(2'b01, 5'd1, 5'd31, 5'd0, 5'd0);
        req_valid = 2'b00; latency(); handshake();

        // Reset on the third BUSY edge aborts the operation
        request(2'b01, 5'd31, 5'd31, 5'd0, 5'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        mprio = 1'b0;
        @(negedge clk);
        chk("abort_mul_out", 32'(mul_out), 32'd0);
        chk("abort_res_id", 32'(res_id), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        pulses = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        // Priority is back on requester 0: 2*3 = 6 first, then 6*6 = 36
        request(2'b11, 5'd2, 5'd3, 5'd6, 5'd6);
        req_valid = 2'b10;
        latency();
        handshake();
        request(2'b10, 5'd2, 5'd3, 5'd6, 5'd6);
        req_valid = 2'b00;
        latency();
        handshake();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
